// File: rtl/idex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : idex_pipe_reg
// Purpose  : Parametrised ID/EX pipeline register with stall, flush, a valid
//            bit and a saturating bubble counter. Define IDEX_HAZARD_DETECT_EN
//            to build in load-use hazard detection.
// Revision : 1.0  initial release
// ============================================================================
module idex_pipe_reg #(
  parameter int DATA_W      = 32,
  parameter int REG_W       = 5,
  parameter int WB_W        = 2,
  parameter int M_W         = 3,
  parameter int ALUOP_W     = 3,
  parameter int MEMREAD_BIT = 1,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 I_stall,
  input  logic                 I_flush,
  input  logic [WB_W-1:0]      I_WB,
  input  logic [M_W-1:0]       I_M,
  input  logic [ALUOP_W+1:0]   I_EX,
  input  logic [DATA_W-1:0]    I_Next_address,
  input  logic [DATA_W-1:0]    I_O1,
  input  logic [DATA_W-1:0]    I_O2,
  input  logic [DATA_W-1:0]    I_Ext_Inmed,
  input  logic [REG_W-1:0]     I_RS,
  input  logic [REG_W-1:0]     I_RT,
  input  logic [REG_W-1:0]     I_RD,
  output logic                 O_valid,
  output logic [WB_W-1:0]      O_WB,
  output logic [M_W-1:0]       O_M,
  output logic                 O_EX_RegDst,
  output logic [ALUOP_W-1:0]   O_EX_ALUOp,
  output logic                 O_EX_ALUSrc,
  output logic [DATA_W-1:0]    O_Next_address,
  output logic [DATA_W-1:0]    O_O1,
  output logic [DATA_W-1:0]    O_O2,
  output logic [DATA_W-1:0]    O_Ext_Inmed,
  output logic [REG_W-1:0]     O_RS,
  output logic [REG_W-1:0]     O_RT,
  output logic [REG_W-1:0]     O_RD,
  output logic                 O_hazard_stall,
  output logic [CNT_W-1:0]     O_bubble_cnt
);

  localparam int EX_W = ALUOP_W + 2;

  // A MemRead index outside the M bundle is a configuration error.
  generate
    if ((MEMREAD_BIT < 0) || (MEMREAD_BIT >= M_W)) begin : g_memread_bit_chk
      $error("idex_pipe_reg: MEMREAD_BIT out of range of M bundle");
    end
  endgenerate

  logic                valid_q, valid_d;
  logic [WB_W-1:0]     wb_q, wb_d;
  logic [M_W-1:0]      m_q, m_d;
  logic [EX_W-1:0]     ex_q, ex_d;
  logic [DATA_W-1:0]   next_addr_q, next_addr_d;
  logic [DATA_W-1:0]   o1_q, o1_d;
  logic [DATA_W-1:0]   o2_q, o2_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic [REG_W-1:0]    rs_q, rs_d;
  logic [REG_W-1:0]    rt_q, rt_d;
  logic [REG_W-1:0]    rd_q, rd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                w_hazard;
  logic                w_bubble;

`ifdef IDEX_HAZARD_DETECT_EN
  // Load in EX whose destination is read by the instruction now in decode.
  assign w_hazard = ~rst & valid_q & m_q[MEMREAD_BIT] & (rt_q != '0)
                  & ((rt_q == I_RS) | (rt_q == I_RT));
`else
  assign w_hazard = 1'b0;
`endif

  assign w_bubble = I_flush | w_hazard;

  always_comb begin
    valid_d     = valid_q;
    wb_d        = wb_q;
    m_d         = m_q;
    ex_d        = ex_q;
    next_addr_d = next_addr_q;
    o1_d        = o1_q;
    o2_d        = o2_q;
    imm_d       = imm_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;

    if (w_bubble || !I_stall) begin
      next_addr_d = I_Next_address;
      o1_d        = I_O1;
      o2_d        = I_O2;
      imm_d       = I_Ext_Inmed;
      rs_d        = I_RS;
      rt_d        = I_RT;
      rd_d        = I_RD;
    end

    if (w_bubble) begin
      // Bubble: control bundles zeroed so the slot has no side effects.
      valid_d = 1'b0;
      wb_d    = '0;
      m_d     = '0;
      ex_d    = '0;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (!I_stall) begin
      valid_d = 1'b1;
      wb_d    = I_WB;
      m_d     = I_M;
      ex_d    = I_EX;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      wb_q        <= '0;
      m_q         <= '0;
      ex_q        <= '0;
      next_addr_q <= '0;
      o1_q        <= '0;
      o2_q        <= '0;
      imm_q       <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      wb_q        <= wb_d;
      m_q         <= m_d;
      ex_q        <= ex_d;
      next_addr_q <= next_addr_d;
      o1_q        <= o1_d;
      o2_q        <= o2_d;
      imm_q       <= imm_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
    end
  end

  assign O_valid        = valid_q;
  assign O_WB           = wb_q;
  assign O_M            = m_q;
  assign O_EX_RegDst    = ex_q[0];
  assign O_EX_ALUOp     = ex_q[ALUOP_W:1];
  assign O_EX_ALUSrc    = ex_q[ALUOP_W+1];
  assign O_Next_address = next_addr_q;
  assign O_O1           = o1_q;
  assign O_O2           = o2_q;
  assign O_Ext_Inmed    = imm_q;
  assign O_RS           = rs_q;
  assign O_RT           = rt_q;
  assign O_RD           = rd_q;
  assign O_hazard_stall = w_hazard;
  assign O_bubble_cnt   = cnt_q;

endmodule
`default_nettype wire
